// File: rtl/child_array_dispatcher.sv
// Round-robin job hub for NUM_CHILD identical child units, with a per-child
// timeout and a single response stream tagged with the child index.
module child_array_dispatcher #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 255,
    parameter int ID_W      = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [DATA_W-1:0]           req_data,
    output logic [NUM_CHILD-1:0]        chd_start,
    output logic [DATA_W-1:0]           chd_data,
    input  logic [NUM_CHILD-1:0]        chd_done,
    input  logic [NUM_CHILD*DATA_W-1:0] chd_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic [NUM_CHILD-1:0]        busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} child_state_t;

    // Counter holds 0 in the first RUN cycle, so the child leaves RUN after exactly TIMEOUT cycles.
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CHILD - 1);

    logic [NUM_CHILD-1:0]             idle_v;
    logic [NUM_CHILD-1:0]             pend_v;
    logic [NUM_CHILD-1:0]             err_v;
    logic [NUM_CHILD-1:0][DATA_W-1:0] res_v;
    logic [NUM_CHILD-1:0]             held_mask;
    logic [NUM_CHILD-1:0]             rsp_cand;
    logic [ID_W-1:0]                  disp_ptr;
    logic [ID_W-1:0]                  rsp_ptr;
    logic [ID_W-1:0]                  disp_sel;
    logic [ID_W-1:0]                  rsp_src;
    logic                             disp_found;
    logic                             rsp_found;
    logic                             accept;
    logic                             rsp_fire;
    logic                             rsp_load;

    function automatic logic [ID_W:0] rr_pick(input logic [NUM_CHILD-1:0] cand,
                                              input logic [ID_W-1:0]      ptr);
        logic [ID_W:0]        pick;
        logic [NUM_CHILD-1:0] rot;
        int unsigned          idx;
        pick = '0;
        for (int unsigned k = 0; k < NUM_CHILD; k++) begin
            idx = (32'(ptr) + k) % NUM_CHILD;
            rot = cand >> idx;
            if (!pick[ID_W] && rot[0]) pick = {1'b1, ID_W'(idx)};
        end
        return pick;
    endfunction

    assign req_ready = |idle_v;
    assign busy      = ~idle_v;
    assign accept    = req_valid && disp_found;
    assign {disp_found, disp_sel} = rr_pick(idle_v, disp_ptr);

    // The child sitting in the output register stays PEND but must not be picked twice.
    assign held_mask = rsp_valid ? (NUM_CHILD'(1) << rsp_id) : '0;
    assign rsp_cand  = pend_v & ~held_mask;
    assign {rsp_found, rsp_src} = rr_pick(rsp_cand, rsp_ptr);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rsp_load  = rsp_found && (!rsp_valid || rsp_ready);

    for (genvar g = 0; g < NUM_CHILD; g++) begin : g_child
        child_state_t       st;
        logic [15:0]        cnt;
        logic [DATA_W-1:0]  res;
        logic               err;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= ST_IDLE;
                cnt <= '0;
                res <= '0;
                err <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (accept && disp_sel == ID_W'(g)) begin
                            st  <= ST_RUN;
                            cnt <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (chd_done[g]) begin
                            st  <= ST_PEND;
                            res <= chd_result[g*DATA_W +: DATA_W];
                            err <= 1'b0;
                        end else if (cnt == TO_LAST) begin
                            st  <= ST_PEND;
                            res <= '0;
                            err <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_PEND: begin
                        if (rsp_fire && rsp_id == ID_W'(g)) st <= ST_IDLE;
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end

        assign idle_v[g] = (st == ST_IDLE);
        assign pend_v[g] = (st == ST_PEND);
        assign res_v[g]  = res;
        assign err_v[g]  = err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_ptr  <= '0;
            chd_start <= '0;
            chd_data  <= '0;
        end else begin
            chd_start <= '0;
            chd_data  <= '0;
            if (accept) begin
                chd_start <= NUM_CHILD'(1) << disp_sel;
                chd_data  <= req_data;
                disp_ptr  <= (disp_sel == LAST_ID) ? '0 : disp_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ptr   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_fire) rsp_valid <= 1'b0;
            if (rsp_load) begin
                rsp_valid <= 1'b1;
                rsp_data  <= res_v[rsp_src];
                rsp_id    <= rsp_src;
                rsp_err   <= err_v[rsp_src];
                rsp_ptr   <= (rsp_src == LAST_ID) ? '0 : rsp_src + 1'b1;
            end
        end
    end

endmodule
